// File: rtl/reg_file_pkg.sv
// Shared types, default sizes and the byte-merge helper for the 2R1W register file.
package reg_file_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Widest entry the merge helper handles; callers cast their operands in and out of this width.
    localparam int MAX_W = 256;
    localparam int MAX_S = MAX_W / 8;

    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0] old_val,
        input logic [MAX_W-1:0] new_val,
        input logic [MAX_S-1:0] strb
    );
        logic [MAX_W-1:0] res;
        res = old_val;
        for (int i = 0; i < MAX_S; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// One registered read port: returns the entry value as it stands after this edge's write or clear.
module reg_file_rdport
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   raddr,
    input  logic [DATA_W-1:0]   mem_val,
    input  logic                wr_fire,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                clr_fire,
    input  logic [ADDR_W-1:0]   clr_addr,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] next_val;

    always_comb begin
        next_val = mem_val;
        if (wr_fire && waddr == raddr) begin
            next_val = DATA_W'(byte_merge(MAX_W'(mem_val), MAX_W'(wdata), MAX_S'(wstrb)));
        end
        if (clr_fire && clr_addr == raddr) next_val = '0;
        if (ZERO_REG != 0 && raddr == '0) next_val = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else        rdata <= next_val;
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// DEPTH-entry register file: one strobed write port, two registered read ports with bypass,
// optional hardwired-zero entry 0 and a one-entry-per-cycle bulk-clear sequencer.
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    output logic                wready,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]   raddr0,
    output logic [DATA_W-1:0]   rdata0,
    input  logic [ADDR_W-1:0]   raddr1,
    output logic [DATA_W-1:0]   rdata1,
    input  logic                clr_req,
    output logic                busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state, next_state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              wr_fire;
    logic              clr_fire;
    logic              wr_store;

    always_comb begin
        next_state = state;
        wready     = 1'b0;
        busy       = 1'b0;
        clr_fire   = 1'b0;
        case (state)
            IDLE: begin
                wready = 1'b1;
                if (clr_req) next_state = CLEAR;
            end
            CLEAR: begin
                busy     = 1'b1;
                clr_fire = 1'b1;
                if (clr_cnt == '1) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign wr_fire  = we && wready;
    assign wr_store = wr_fire && !(ZERO_REG != 0 && waddr == '0);

    // The counter wraps to 0 on the same edge the sweep returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && clr_req) clr_cnt <= '0;
            else if (clr_fire)            clr_cnt <= clr_cnt + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_store) begin
                mem[waddr] <= DATA_W'(byte_merge(MAX_W'(mem[waddr]), MAX_W'(wdata), MAX_S'(wstrb)));
            end
            if (clr_fire) mem[clr_cnt] <= '0;
        end
    end

    reg_file_rdport #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr    (raddr0),
        .mem_val  (mem[raddr0]),
        .wr_fire  (wr_fire),
        .waddr    (waddr),
        .wstrb    (wstrb),
        .wdata    (wdata),
        .clr_fire (clr_fire),
        .clr_addr (clr_cnt),
        .rdata    (rdata0)
    );

    reg_file_rdport #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_rd1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr    (raddr1),
        .mem_val  (mem[raddr1]),
        .wr_fire  (wr_fire),
        .waddr    (waddr),
        .wstrb    (wstrb),
        .wdata    (wdata),
        .clr_fire (clr_fire),
        .clr_addr (clr_cnt),
        .rdata    (rdata1)
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: vector table for writes/bypass/zero entry, then clear-sweep sequences.
module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [4:0]  raddr0;
    logic [4:0]  raddr1;
    logic        clr_req;
    logic        wready, busy, wready_nz, busy_nz;
    logic [31:0] rdata0, rdata1, rdata0_nz, rdata1_nz;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wready(wready), .waddr(waddr),
        .wstrb(wstrb), .wdata(wdata), .raddr0(raddr0), .rdata0(rdata0),
        .raddr1(raddr1), .rdata1(rdata1), .clr_req(clr_req), .busy(busy)
    );

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .we(we), .wready(wready_nz), .waddr(waddr),
        .wstrb(wstrb), .wdata(wdata), .raddr0(raddr0), .rdata0(rdata0_nz),
        .raddr1(raddr1), .rdata1(rdata1_nz), .clr_req(clr_req), .busy(busy_nz)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e0_nz;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        we     = v.we;
        waddr  = v.waddr;
        wstrb  = v.wstrb;
        wdata  = v.wdata;
        raddr0 = v.r0;
        raddr1 = v.r1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd3, 4'hf, 32'haaaaaaaa, 5'd3, 5'd4, 32'haaaaaaaa, 32'h0,        32'haaaaaaaa};
        vecs[1] = '{1'b0, 5'd0, 4'h0, 32'h0,        5'd3, 5'd4, 32'haaaaaaaa, 32'h0,        32'haaaaaaaa};
        vecs[2] = '{1'b1, 5'd3, 4'h5, 32'h55555555, 5'd3, 5'd3, 32'haa55aa55, 32'haa55aa55, 32'haa55aa55};
        vecs[3] = '{1'b1, 5'd0, 4'hf, 32'hffffffff, 5'd0, 5'd3, 32'h0,        32'haa55aa55, 32'hffffffff};
        vecs[4] = '{1'b0, 5'd0, 4'h0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'hffffffff};
        vecs[5] = '{1'b1, 5'd5, 4'h0, 32'h12345678, 5'd5, 5'd3, 32'h0,        32'haa55aa55, 32'h0};
        vecs[6] = '{1'b1, 5'd5, 4'h8, 32'h12345678, 5'd5, 5'd5, 32'h12000000, 32'h12000000, 32'h12000000};
        vecs[7] = '{1'b1, 5'd5, 4'h2, 32'h9abcdef0, 5'd5, 5'd3, 32'h1200de00, 32'haa55aa55, 32'h1200de00};

        rst_n = 1'b0; we = 0; waddr = 0; wstrb = 0; wdata = 0;
        raddr0 = 0; raddr1 = 0; clr_req = 0;
        step(); step();
        checkOutput("reset_rdata0", rdata0, 32'h0);
        checkOutput("reset_rdata1", rdata1, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        checkOutput("reset_wready", {31'b0, wready}, 32'h1);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_wready", i), {31'b0, wready}, 32'h1);
            step();
            checkOutput($sformatf("vec%0d_rdata0", i), rdata0, vecs[i].e0);
            checkOutput($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].e1);
            checkOutput($sformatf("vec%0d_rdata0_nz", i), rdata0_nz, vecs[i].e0_nz);
        end

        // Fill every entry, then sweep with a stalled write and a redundant clr_req mid-sweep.
        we = 1; wstrb = 4'hf; wdata = 32'hffffffff;
        for (int a = 0; a < 32; a++) begin
            waddr = 5'(a);
            step();
        end
        we = 0; raddr0 = 5'd31; raddr1 = 5'd7; clr_req = 1;
        step();
        clr_req = 0;
        we = 1; waddr = 5'd7; wstrb = 4'hf; wdata = 32'h12345678;
        for (int j = 0; j <= 33; j++) begin
            checkOutput($sformatf("sweep%0d_busy", j), {31'b0, busy}, (j <= 31) ? 32'h1 : 32'h0);
            checkOutput($sformatf("sweep%0d_wready", j), {31'b0, wready}, (j <= 31) ? 32'h0 : 32'h1);
            checkOutput($sformatf("sweep%0d_rd31", j), rdata0, (j <= 31) ? 32'hffffffff : 32'h0);
            checkOutput($sformatf("sweep%0d_rd7", j), rdata1,
                        (j <= 7) ? 32'hffffffff : ((j <= 32) ? 32'h0 : 32'h12345678));
            clr_req = (j == 9);
            if (j == 33) we = 0;
            step();
        end
        clr_req = 0;
        checkOutput("post_sweep_busy", {31'b0, busy}, 32'h0);
        raddr0 = 5'd12; raddr1 = 5'd7;
        step();
        checkOutput("post_sweep_rd12", rdata0, 32'h0);
        checkOutput("post_sweep_rd7", rdata1, 32'h12345678);

        // Asynchronous reset in the middle of a sweep.
        we = 1; waddr = 5'd9; wstrb = 4'hf; wdata = 32'hcafef00d;
        step();
        we = 0; raddr0 = 5'd9; raddr1 = 5'd7; clr_req = 1;
        step();
        clr_req = 0;
        for (int k = 0; k < 5; k++) step();
        checkOutput("midclr_busy", {31'b0, busy}, 32'h1);
        checkOutput("midclr_rd9", rdata0, 32'hcafef00d);
        checkOutput("midclr_rd7", rdata1, 32'h12345678);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", {31'b0, busy}, 32'h0);
        checkOutput("async_rst_rdata0", rdata0, 32'h0);
        checkOutput("async_rst_rdata1", rdata1, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("after_rst_wready", {31'b0, wready}, 32'h1);
        checkOutput("after_rst_busy", {31'b0, busy}, 32'h0);
        checkOutput("after_rst_rd9", rdata0, 32'h0);
        checkOutput("after_rst_rd7", rdata1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
Parametrised successor to the single 32-bit R/W register: a DEPTH-entry register file with one write port and two registered read ports. Adds per-byte write strobes, write-to-read bypass and an optional hardwired-zero entry 0. A handshaked bulk-clear sequencer zeroes every entry, one per cycle. Sits in CORE as the integer register file; feeds decode and operand-fetch.

Parameters:
DATA_W, 32, entry width in bits; must be a multiple of 8
ADDR_W, 5, address width; DEPTH = 2**ADDR_W
ZERO_REG, 1, 1: entry 0 reads as 0 and ignores writes; 0: entry 0 is an ordinary entry

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
we  in  1  write request
wready  out  1  write accepted when we && wready (combinational; 1 in IDLE, 0 in CLEAR)
waddr  in  ADDR_W  write address
wstrb  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i]
wdata  in  DATA_W  write data
raddr0  in  ADDR_W  read port 0 address
rdata0  out  DATA_W  read port 0 data, registered
raddr1  in  ADDR_W  read port 1 address
rdata1  out  DATA_W  read port 1 data, registered
clr_req  in  1  single-cycle bulk-clear request
busy  out  1  clear sequence in progress

Behaviour:
- Reset (rst_n=0, asynchronous, any state): all entries 0; rdata0/rdata1 0; busy 0; state IDLE; clear counter 0. Reset during CLEAR aborts the sequence; everything is zero.
- Write fire = we && wready. On the clk edge, entry[waddr] byte i <= wdata byte i where wstrb[i]=1; other bytes hold. wstrb=0 is a legal no-op.
- With ZERO_REG=1, a write to address 0 fires (wready unaffected) but the stored value stays 0.
- Read: 1-cycle latency. At each edge, rdataN <= value of entry[raddrN] as it stands after that edge's update:
  - same-cycle write to raddrN: bypass; merged old/new bytes per wstrb.
  - same-cycle clear of raddrN: 0.
  - ZERO_REG=1 and raddrN=0: 0.
  - Both ports may address the same entry; both see the same result.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_req=1; counter <= 0. A write firing in the same cycle is performed, then overwritten by the sweep.
  - In CLEAR, each cycle entry[counter] <= 0 and counter increments. After entry DEPTH-1 is cleared -> IDLE.
  - busy=1 exactly DEPTH cycles, starting the cycle after the request edge.
  - clr_req in CLEAR is ignored (no restart, no queuing).
  - we in CLEAR is stalled (wready=0); the requester holds we/waddr/wstrb/wdata until wready.
  - Reads in CLEAR remain valid: entries not yet swept return old data; swept entries return 0.
- Counter width ADDR_W; its wrap from DEPTH-1 to 0 coincides with the exit to IDLE.

Decomposition:
- Shared package reg_file_pkg: state typedef {IDLE, CLEAR}; default DATA_W/ADDR_W constants; byte-merge function (old, new, strb).
- Sub-module reg_file_rdport: one registered read port with bypass and zero-entry logic, instantiated twice.

Test Plan:
- Reset, then write 32'haaaaaaaa to addr 3 with wstrb=4'hf; raddr0=3 -> rdata0=32'haaaaaaaa one cycle later; rdata1 with raddr1=4 stays 0.
- addr 3 holds 32'haaaaaaaa; write 32'h55555555, wstrb=4'b0101, raddr0=raddr1=3 in the same cycle -> both rdata = 32'haa55aa55 after that edge (bypass).
- ZERO_REG=1: write 32'hffffffff to addr 0 -> wready=1, rdata0 for addr 0 stays 0; with ZERO_REG=0 it reads 32'hffffffff.
- Fill all 32 entries with 32'hffffffff; pulse clr_req -> busy high exactly 32 cycles.
  - During the sweep, we=1 sees wready=0 and is held.
  - addr 31 reads ffffffff until swept, then 0.
  - The held write lands the first IDLE cycle.
- clr_req pulsed again at sweep cycle 10 -> ignored; busy still falls after cycle 32.
- Assert rst_n=0 mid-clear at cycle 5 -> busy, rdata0, rdata1 go 0 immediately without a clock edge; after release, all entries read 0 and wready=1.
